// File: rtl/shared_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shared_bus_pkg
// Purpose : Shared types and helpers for the shared bus arbiter.
//           - state_t   : arbiter FSM state encoding
//           - rr_pick_t : result of a round-robin search (found flag + index)
//           - rr_pick() : first asserted request at or after a pointer,
//                         wrapping at the number of active drivers
// Revision: 1.0 - initial release
// ============================================================================
package shared_bus_pkg;

  localparam int MAX_DRV   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans num candidates starting at ptr. Candidates at or above num are
  // never examined, so req bits beyond the active driver count are ignored.
  function automatic rr_pick_t rr_pick(input logic [MAX_DRV-1:0]   req,
                                       input logic [MAX_IDX_W-1:0] ptr,
                                       input int                   num);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < MAX_DRV; k++) begin
      if (k < num) begin
        j = int'(ptr) + k;
        if (j >= num) j = j - num;
        if (!r.found && req[j]) begin
          r.found = 1'b1;
          r.idx   = MAX_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_conflict_mon.sv
`default_nettype none
// ============================================================================
// Module  : bus_conflict_mon
// Purpose : Watches the enables of every driver on the shared net.
//           Counts active enables, flags a uniquely driven net, and records
//           contention in a sticky flag plus a saturating cycle counter.
// Ports   : clk, rst_n       - clock, async active-low reset
//           grant[NUM_DRV]   - arbitrated driver enables
//           ext_en           - external driver enable
//           bus_valid        - exactly one enable active (combinational)
//           conflict         - sticky contention flag
//           conflict_cnt     - saturating count of contention cycles
// Revision: 1.0 - initial release
// ============================================================================
module bus_conflict_mon #(
  parameter int NUM_DRV = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DRV-1:0] grant,
  input  logic               ext_en,
  output logic               bus_valid,
  output logic               conflict,
  output logic [CNT_W-1:0]   conflict_cnt
);

  localparam int EC_W = $clog2(NUM_DRV + 2);

  logic [EC_W-1:0] w_enabled_count;
  logic            w_contention;

  always_comb begin
    w_enabled_count = EC_W'(ext_en);
    for (int i = 0; i < NUM_DRV; i++) begin
      w_enabled_count = w_enabled_count + EC_W'(grant[i]);
    end
  end

  assign bus_valid    = (w_enabled_count == EC_W'(1));
  assign w_contention = (w_enabled_count > EC_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (w_contention) begin
      conflict <= 1'b1;
      if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shared_bus_arbiter
// Purpose : Round-robin arbiter placing NUM_DRV requesters onto one resolved
//           tri net, with a per-owner hold limit and a one-cycle turnaround
//           between owners. An unarbitrated external driver shares the net;
//           contention is detected and counted, never corrected.
// Ports   : clk, rst_n  - clock, async active-low reset
//           req         - per-driver level request
//           drv_data    - driver i data at [i*WIDTH +: WIDTH]
//           ext_en/data - external driver
//           grant       - registered one-hot ownership
//           owner_id    - current/last owner index
//           bus         - resolved net value
//           bus_valid   - exactly one driver enabled
//           conflict    - sticky contention flag
//           conflict_cnt- saturating contention cycle count
// Config  : SHARED_BUS_ARBITER_PARK_EN - weakly park the idle net at zero
// Revision: 1.0 - initial release
// ============================================================================
module shared_bus_arbiter
  import shared_bus_pkg::*;
#(
  parameter int NUM_DRV  = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_DRV-1:0]         req,
  input  logic [NUM_DRV*WIDTH-1:0]   drv_data,
  input  logic                       ext_en,
  input  logic [WIDTH-1:0]           ext_data,
  output logic [NUM_DRV-1:0]         grant,
  output logic [$clog2(NUM_DRV)-1:0] owner_id,
  output tri   [WIDTH-1:0]           bus,
  output logic                       bus_valid,
  output logic                       conflict,
  output logic [CNT_W-1:0]           conflict_cnt
);

  localparam int OID_W  = $clog2(NUM_DRV);
  localparam int HOLD_W = 8;

  state_t             r_state,  w_state_nxt;
  logic [NUM_DRV-1:0] w_grant_nxt;
  logic [OID_W-1:0]   w_owner_nxt;
  logic [OID_W-1:0]   r_rr_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0]  r_hold,   w_hold_nxt;
  logic [MAX_DRV-1:0] w_req_ext;
  rr_pick_t           w_pick;

  assign w_req_ext = MAX_DRV'(req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      r_rr_ptr <= '0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      grant    <= w_grant_nxt;
      owner_id <= w_owner_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
    end
  end

  // TURNAROUND shares the arbitration of IDLE: its single grant-free cycle
  // is the evaluation cycle, so the gap between owners is exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = grant;
    w_owner_nxt = owner_id;
    w_ptr_nxt   = r_rr_ptr;
    w_hold_nxt  = r_hold;
    w_pick      = rr_pick(w_req_ext, MAX_IDX_W'(r_rr_ptr), NUM_DRV);
    case (r_state)
      IDLE, TURNAROUND: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
        if (w_pick.found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = NUM_DRV'(1) << w_pick.idx;
          w_owner_nxt = OID_W'(w_pick.idx);
          w_ptr_nxt   = (w_pick.idx == MAX_IDX_W'(NUM_DRV - 1)) ? '0
                                                                : OID_W'(w_pick.idx) + OID_W'(1);
          w_hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (!req[owner_id] || (r_hold == HOLD_W'(HOLD_MAX))) begin
          w_grant_nxt = '0;
          w_state_nxt = TURNAROUND;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shared net: one conditional driver per requester plus the external one.
  tri [WIDTH-1:0] w_net;

  for (genvar i = 0; i < NUM_DRV; i++) begin : g_drv
    assign w_net = grant[i] ? drv_data[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
  end

  assign w_net = ext_en ? ext_data : {WIDTH{1'bz}};

`ifdef SHARED_BUS_ARBITER_PARK_EN
  // Pull-strength zero keeper; any strong driver overrides it, and it is
  // invisible to the enable count in the conflict monitor.
  logic w_park;
  assign w_park = (r_state == IDLE) && (req == '0);
  assign (pull0, highz1) w_net = {WIDTH{~w_park}};
`endif

  assign bus = w_net;

  bus_conflict_mon #(
    .NUM_DRV (NUM_DRV),
    .CNT_W   (CNT_W)
  ) u_mon (
    .clk          (clk),
    .rst_n        (rst_n),
    .grant        (grant),
    .ext_en       (ext_en),
    .bus_valid    (bus_valid),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule
`default_nettype wire
